// File: rtl/reg_file.sv
// 2**AW x WIDTH register file: one write port, two combinational read ports, r0 hardwired to zero.
// Optional macro REG_FILE_BYPASS_EN forwards same-cycle write data to a matching read port.
module reg_file #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr1,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2
);

  localparam int N = 2 ** AW;

  logic [WIDTH-1:0] regs_q [N];
  logic [WIDTH-1:0] regs_d [N];
  logic             wr_en;

  assign wr_en = we && (waddr != '0) && !rst;

  // Reset outranks any write presented on the same edge.
  always_comb begin
    regs_d = regs_q;
    if (rst) begin
      for (int i = 0; i < N; i++) regs_d[i] = '0;
    end else if (wr_en) begin
      regs_d[waddr] = wdata;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

`ifdef REG_FILE_BYPASS_EN
  always_comb begin
    rdata1 = (wr_en && raddr1 == waddr) ? wdata : regs_q[raddr1];
    rdata2 = (wr_en && raddr2 == waddr) ? wdata : regs_q[raddr2];
  end
`else
  always_comb begin
    rdata1 = regs_q[raddr1];
    rdata2 = regs_q[raddr2];
  end
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file (default build; expectations adapt to REG_FILE_BYPASS_EN).
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;

  int checks = 0;
  int errors = 0;

  reg_file #(.WIDTH(32), .AW(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'hFFFF_0000;
    tick();
    rst = 1'b0; we = 1'b0;
    for (int a = 0; a < 32; a++) begin
      raddr1 = a[4:0];
      raddr2 = 5'(31 - a);
      #1;
      checks++;
      if (rdata1 !== 32'h0) begin
        errors++;
        $display("FAIL reset_rd1[%0d]: got %h expected 00000000", a, rdata1);
      end
      checks++;
      if (rdata2 !== 32'h0) begin
        errors++;
        $display("FAIL reset_rd2[%0d]: got %h expected 00000000", 31 - a, rdata2);
      end
    end
  endtask

  task automatic test_write_read();
    wr(5'd5, 32'hDEAD_BEEF);
    wr(5'd31, 32'h1234_5678);
    raddr1 = 5'd5; raddr2 = 5'd31; #1;
    checks++;
    if (rdata1 !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_r5: got %h expected deadbeef", rdata1);
    end
    checks++;
    if (rdata2 !== 32'h1234_5678) begin
      errors++; $display("FAIL wr_r31: got %h expected 12345678", rdata2);
    end
    raddr1 = 5'd6; raddr2 = 5'd4; #1;
    checks++;
    if (rdata1 !== 32'h0) begin
      errors++; $display("FAIL wr_r6_untouched: got %h expected 00000000", rdata1);
    end
    checks++;
    if (rdata2 !== 32'h0) begin
      errors++; $display("FAIL wr_r4_untouched: got %h expected 00000000", rdata2);
    end
    raddr1 = 5'd5; raddr2 = 5'd5; #1;
    checks++;
    if (rdata1 !== 32'hDEAD_BEEF || rdata2 !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL same_addr: got %h/%h expected deadbeef/deadbeef", rdata1, rdata2);
    end
  endtask

  task automatic test_zero_reg();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr1 = 5'd0; raddr2 = 5'd0; #1;
    checks++;
    if (rdata1 !== 32'h0) begin
      errors++; $display("FAIL zero_no_bypass: got %h expected 00000000", rdata1);
    end
    tick();
    we = 1'b0; #1;
    checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      errors++; $display("FAIL zero_reg: got %h/%h expected 00000000", rdata1, rdata2);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp_mid;
`ifdef REG_FILE_BYPASS_EN
    exp_mid = 32'h2;
`else
    exp_mid = 32'h1;
`endif
    wr(5'd7, 32'h1);
    raddr1 = 5'd7; raddr2 = 5'd7;
    we = 1'b1; waddr = 5'd7; wdata = 32'h2; #1;
    checks++;
    if (rdata1 !== exp_mid) begin
      errors++; $display("FAIL same_cycle_rd1: got %h expected %h", rdata1, exp_mid);
    end
    checks++;
    if (rdata2 !== exp_mid) begin
      errors++; $display("FAIL same_cycle_rd2: got %h expected %h", rdata2, exp_mid);
    end
    tick();
    we = 1'b0; #1;
    checks++;
    if (rdata1 !== 32'h2) begin
      errors++; $display("FAIL after_edge_r7: got %h expected 00000002", rdata1);
    end
  endtask

  task automatic test_hold();
    wr(5'd3, 32'h0000_0077);
    we = 1'b0; waddr = 5'd3; wdata = 32'h0000_0099; raddr1 = 5'd3; raddr2 = 5'd31;
    tick();
    checks++;
    if (rdata1 !== 32'h77) begin
      errors++; $display("FAIL hold_r3: got %h expected 00000077", rdata1);
    end
    checks++;
    if (rdata2 !== 32'h1234_5678) begin
      errors++; $display("FAIL hold_r31: got %h expected 12345678", rdata2);
    end
  endtask

  task automatic test_reset_priority();
    rst = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5_A5A5;
    raddr1 = 5'd3; raddr2 = 5'd5; #1;
    checks++;
    if (rdata1 !== 32'h77) begin
      errors++; $display("FAIL rst_no_bypass: got %h expected 00000077", rdata1);
    end
    tick();
    rst = 1'b0; we = 1'b0;
    checks++;
    if (rdata1 !== 32'h0) begin
      errors++; $display("FAIL rst_prio_r3: got %h expected 00000000", rdata1);
    end
    checks++;
    if (rdata2 !== 32'h0) begin
      errors++; $display("FAIL rst_clear_r5: got %h expected 00000000", rdata2);
    end
    wdata = 32'h5A5A_5A5A;
    tick();
    checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      errors++; $display("FAIL we0_no_change: got %h/%h expected 00000000", rdata1, rdata2);
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_same_cycle();
    test_hold();
    test_reset_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter AW, default 5, address width; register count = 2**AW.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port we  input  1  write enable; write occurs on a rising edge where we=1.
REQ-006 SHALL have port waddr  input  AW  write address, decoded one-hot (1:N demux) to a single register.
REQ-007 SHALL have port wdata  input  WIDTH  write data.
REQ-008 SHALL have port raddr1  input  AW  read port 1 address.
REQ-009 SHALL have port raddr2  input  AW  read port 2 address.
REQ-010 SHALL have port rdata1  output  WIDTH  read port 1 data (N:1 mux of array).
REQ-011 SHALL have port rdata2  output  WIDTH  read port 2 data (N:1 mux of array).

Function
REQ-012 SHALL hold 2**AW registers of WIDTH bits; register 0 is hardwired to zero.
REQ-013 SHALL, on a rising clk edge with rst=0, we=1 and waddr!=0, load wdata into register waddr only; all other registers hold.
REQ-014 SHALL ignore writes with waddr=0; register 0 reads 0 at all times.
REQ-015 SHALL hold all registers when we=0.
REQ-016 SHALL drive rdata1/rdata2 combinationally from the array: zero latency on address change, new write value visible the cycle after the write edge.
REQ-017 SHALL allow raddr1=raddr2, both ports returning identical data.
REQ-018 SHALL treat we, waddr, wdata as don't-care while rst=1; reset has priority over write on the same edge.
REQ-019 SHALL contain no X-propagating state after the first reset edge; reads of any address are defined.

Reset
REQ-020 SHALL clear every register to 0 on a rising clk edge with rst=1.
REQ-021 SHALL produce rdata1=rdata2=0 for all addresses from the edge after rst is sampled high until the first subsequent write.
REQ-022 SHALL, on rst asserted mid-sequence, discard any write presented on that edge; no partial update.

Configuration
REQ-023 SHALL honour macro REG_FILE_BYPASS_EN: when defined, a read port whose address equals waddr while we=1, waddr!=0 and rst=0 returns wdata in the same cycle (write-through forwarding).
REQ-024 SHALL, when REG_FILE_BYPASS_EN is undefined, return the stored (pre-write) value during the write cycle, per REQ-016.
REQ-025 SHALL keep bypass off for waddr=0 and during rst=1 in both builds.

Verification
REQ-026 Reset: rst=1 one edge, then raddr1 sweeps 0..31 -> rdata1=0 for all.
REQ-027 Write/read: write 0xDEADBEEF to r5, 0x12345678 to r31; raddr1=5, raddr2=31 -> 0xDEADBEEF, 0x12345678; r6 still 0.
REQ-028 Zero register: we=1, waddr=0, wdata=0xFFFFFFFF -> rdata1 at raddr1=0 remains 0.
REQ-029 Same-cycle read/write at r7 (old 0x1, new 0x2): with REG_FILE_BYPASS_EN rdata1=0x2 in that cycle; without, 0x1, then 0x2 after the edge.
REQ-030 Reset priority: rst=1 and we=1, waddr=3, wdata=0xA5A5A5A5 same edge -> r3 reads 0; we=0 edge with wdata change -> no register changes.
